// File: rtl/lag_pl_link_allocator.sv
// rtl/lag_pl_link_allocator.sv - per-output-port round-robin allocator of physical links to requesting PLs.
// Links are scanned in ascending order; each link keeps its own round-robin pointer.
module lag_pl_link_allocator #(
  parameter int num_pls       = 4,
  parameter int max_links_num = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [num_pls-1:0]                 req_i,
  input  logic [num_pls*max_links_num-1:0]   req_links_i,
  input  logic [num_pls-1:0]                 held_i,
  input  logic [num_pls-1:0]                 release_i,
  input  logic [num_pls*max_links_num-1:0]   release_link_i,
  output logic [num_pls*max_links_num-1:0]   pl_new_o,
  output logic [num_pls-1:0]                 pl_new_valid_o,
  output logic [max_links_num-1:0]           link_busy_o,
  output logic                               err_o
);

  localparam int PtrW = (num_pls > 1) ? $clog2(num_pls) : 1;

  logic [max_links_num-1:0] link_busy_q, link_busy_d;
  logic [PtrW-1:0]          rr_q [max_links_num];
  logic [PtrW-1:0]          rr_d [max_links_num];
  logic                     err_q, err_d;

  logic [num_pls-1:0]                 eligible;
  logic [num_pls-1:0]                 taken;
  logic [num_pls*max_links_num-1:0]   pl_new;
  logic [max_links_num-1:0]           grant;
  logic [PtrW-1:0]                    win [max_links_num];
  logic                               found;
  int                                 idx;

  // A releasing requester is excluded so its link cannot bounce straight back to it.
  assign eligible = req_i & ~held_i & ~release_i;

  always_comb begin
    taken  = '0;
    pl_new = '0;
    grant  = '0;
    found  = 1'b0;
    idx    = 0;
    for (int l = 0; l < max_links_num; l++) begin
      win[l] = '0;
      found  = 1'b0;
      for (int k = 0; k < num_pls; k++) begin
        idx = (int'(rr_q[l]) + k) % num_pls;
        if (!found && !link_busy_q[l] && eligible[idx] &&
            req_links_i[idx*max_links_num+l] && !taken[idx]) begin
          found                          = 1'b1;
          win[l]                         = idx[PtrW-1:0];
          taken[idx]                     = 1'b1;
          pl_new[idx*max_links_num+l]    = 1'b1;
        end
      end
      grant[l] = found;
    end
    if (!rst_n) begin
      taken  = '0;
      pl_new = '0;
      grant  = '0;
    end
  end

  assign pl_new_o       = pl_new;
  assign pl_new_valid_o = taken;

  logic [num_pls-1:0] row_onehot;
  int                 rel_cnt;
  logic               rel_good;

  // A link is freed only by exactly one well-formed releaser; anything else flags err and leaves it alone.
  always_comb begin
    err_d       = err_q;
    link_busy_d = link_busy_q;
    rel_cnt     = 0;
    rel_good    = 1'b0;
    for (int i = 0; i < num_pls; i++) begin
      row_onehot[i] = $onehot(release_link_i[i*max_links_num +: max_links_num]);
      if (release_i[i] && !row_onehot[i]) err_d = 1'b1;
    end
    for (int l = 0; l < max_links_num; l++) begin
      rel_cnt  = 0;
      rel_good = 1'b0;
      rr_d[l]  = rr_q[l];
      for (int i = 0; i < num_pls; i++) begin
        if (release_i[i] && release_link_i[i*max_links_num+l]) begin
          rel_cnt++;
          if (row_onehot[i]) rel_good = 1'b1;
        end
      end
      if (rel_cnt > 1) begin
        err_d = 1'b1;
      end else if (rel_cnt == 1 && rel_good) begin
        if (link_busy_q[l]) link_busy_d[l] = 1'b0;
        else                err_d          = 1'b1;
      end
      if (grant[l]) begin
        link_busy_d[l] = 1'b1;
        rr_d[l]        = PtrW'((int'(win[l]) + 1) % num_pls);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_busy_q <= '0;
      err_q       <= 1'b0;
      for (int l = 0; l < max_links_num; l++) rr_q[l] <= '0;
    end else begin
      link_busy_q <= link_busy_d;
      err_q       <= err_d;
      for (int l = 0; l < max_links_num; l++) rr_q[l] <= rr_d[l];
    end
  end

  assign link_busy_o = link_busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lag_pl_link_allocator.sv
// tb/tb_lag_pl_link_allocator.sv - scoreboard bench for lag_pl_link_allocator with a queue-based reference model.
module tb_lag_pl_link_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, held, rel, valid;
  logic [7:0] req_links, rel_link, pl_new;
  logic [1:0] link_busy;
  logic       err;

  always #5 clk = ~clk;

  lag_pl_link_allocator #(.num_pls(4), .max_links_num(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req), .req_links_i(req_links), .held_i(held),
    .release_i(rel), .release_link_i(rel_link),
    .pl_new_o(pl_new), .pl_new_valid_o(valid),
    .link_busy_o(link_busy), .err_o(err)
  );

  typedef struct {
    logic [7:0] pl;
    logic [3:0] v;
    logic [1:0] busy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: who owns which link, busy set, per-link next-preferred requester, sticky error.
  int owner[4];
  bit m_busy[2];
  int m_next[2];
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pl_new", 32'(pl_new), 32'(e.pl));
        check("pl_new_valid", 32'(valid), 32'(e.v));
        check("link_busy", 32'(link_busy), 32'(e.busy));
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic drive(input bit [3:0] rq, input bit [7:0] rl, input bit [3:0] xhd,
                       input bit [3:0] relo, input bit [3:0] bogus_rel,
                       input bit [7:0] bogus_rll, input bit rn);
    exp_t     e;
    bit [3:0] own, hd, rl_en, taken;
    bit [7:0] rll;
    int       users[$];
    int       cand[$];
    @(posedge clk);
    #1;
    rll = bogus_rll;
    for (int i = 0; i < 4; i++) begin
      own[i] = (owner[i] >= 0);
      if (relo[i] && own[i]) rll[2*i+owner[i]] = 1'b1;
    end
    hd    = xhd | own;
    rl_en = (relo & own) | bogus_rel;
    rst_n = rn; req = rq; req_links = rl; held = hd; rel = rl_en; rel_link = rll;

    e.busy = {m_busy[1], m_busy[0]};
    e.err  = m_err;
    e.pl   = '0;
    e.v    = '0;
    taken  = '0;
    if (rn) begin
      for (int l = 0; l < 2; l++) begin
        if (m_busy[l]) continue;
        // candidates listed in rotation order starting from the preferred requester
        cand.delete();
        for (int k = 0; k < 4; k++) cand.push_back((m_next[l] + k) % 4);
        foreach (cand[c]) begin
          if (rq[cand[c]] && !hd[cand[c]] && !rl_en[cand[c]] && rl[2*cand[c]+l] && !taken[cand[c]]) begin
            taken[cand[c]]     = 1'b1;
            e.v[cand[c]]       = 1'b1;
            e.pl[2*cand[c]+l]  = 1'b1;
            break;
          end
        end
      end
    end
    sb.push_back(e);

    if (!rn) begin
      for (int l = 0; l < 2; l++) begin m_busy[l] = 0; m_next[l] = 0; end
      for (int i = 0; i < 4; i++) owner[i] = -1;
      m_err = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (rl_en[i] && $countones(rll[2*i +: 2]) != 1) m_err = 1;
      for (int l = 0; l < 2; l++) begin
        users.delete();
        for (int i = 0; i < 4; i++) if (rl_en[i] && rll[2*i+l]) users.push_back(i);
        if (users.size() > 1) m_err = 1;
        else if (users.size() == 1 && $countones(rll[2*users[0] +: 2]) == 1) begin
          if (m_busy[l]) m_busy[l] = 0;
          else           m_err = 1;
        end
      end
      for (int i = 0; i < 4; i++) if (relo[i] && own[i]) owner[i] = -1;
      for (int i = 0; i < 4; i++)
        for (int l = 0; l < 2; l++)
          if (e.pl[2*i+l]) begin m_busy[l] = 1; m_next[l] = (i + 1) % 4; owner[i] = l; end
    end
  endtask

  initial begin : stim
    bit [3:0] br;
    bit [7:0] bl;
    int       r;
    rst_n = 1'b0; req = '0; req_links = '0; held = '0; rel = '0; rel_link = '0;
    for (int i = 0; i < 4; i++) owner[i] = -1;
    for (int l = 0; l < 2; l++) begin m_busy[l] = 0; m_next[l] = 0; end
    m_err = 0;
    repeat (2) @(posedge clk);

    // two requesters, both links free
    drive(4'b0011, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    // free link 1, then all want link 0 while busy, then release link 0
    drive(4'b0000, 8'h00, 4'b0000, 4'b0010, 4'b0000, 8'h00, 1'b1);
    drive(4'b1111, 8'h55, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    drive(4'b1111, 8'h55, 4'b0000, 4'b0001, 4'b0000, 8'h00, 1'b1);
    drive(4'b1111, 8'h55, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    // round-robin on link 0 with owners releasing right after their grant
    repeat (10) drive(4'b1111, 8'h55, 4'b0000, 4'b1111, 4'b0000, 8'h00, 1'b1);
    // requester 2 marked held must never win
    repeat (8) drive(4'b1111, 8'hFF, 4'b0100, 4'b1111, 4'b0000, 8'h00, 1'b1);
    // fill both links, then reset with requests active
    drive(4'b1111, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    drive(4'b1111, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    // release of an idle link sets sticky err; grants restart from requester 0
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b1000, 8'h80, 1'b1);
    drive(4'b0011, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    repeat (3) drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    // zero candidate mask is never granted and is not an error
    drive(4'b1111, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    // two releasers on one link and a non-one-hot release
    drive(4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0001, 4'b0010, 8'h04, 1'b1);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0100, 8'h30, 1'b1);
    drive(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b0);

    for (int c = 0; c < 600; c++) begin
      br = '0; bl = '0;
      if ($urandom_range(0, 29) == 0) begin
        r  = $urandom_range(0, 3);
        br = 4'(1 << r);
        bl = 8'($urandom_range(0, 3) << (2 * r));
      end
      drive(4'($urandom), 8'($urandom),
            ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000,
            4'($urandom) & 4'($urandom), br, bl, $urandom_range(0, 99) != 0);
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
